tower_build_ctrl: RTL and testbench

TOWER_BUILD_CTRL -- requirements
Module: tower_build_ctrl

---
 rtl/tower_build_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_tower_build_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/tower_build_ctrl.sv
// Tower build/sell controller: validates place/sell commands, pulses the target slot, tracks coins and occupancy.
// Optional macro TOWER_SELL_REFUND_EN credits half the stored tower cost back on a sell.
module tower_build_ctrl #(
    parameter int NUM_SLOTS   = 8,
    parameter int COIN_W      = 12,
    parameter int START_COINS = 200
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_sell,
    input  logic [2:0]           cmd_slot,
    input  logic [2:0]           cmd_type,
    input  logic                 coin_add_valid,
    input  logic [7:0]           coin_add,
    output logic [NUM_SLOTS-1:0] tower_enable,
    output logic [NUM_SLOTS-1:0] tower_sell,
    output logic [2:0]           tower_type,
    output logic [COIN_W-1:0]    coins,
    output logic [NUM_SLOTS-1:0] occupied,
    output logic                 resp_valid,
    output logic [1:0]           resp_code
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CHECK  = 2'd1,
        S_COMMIT = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    localparam logic [1:0] RC_OK    = 2'b00;
    localparam logic [1:0] RC_COINS = 2'b01;
    localparam logic [1:0] RC_SLOT  = 2'b10;
    localparam logic [1:0] RC_BAD   = 2'b11;
    localparam logic [3:0] SLOT_LIMIT = 4'(NUM_SLOTS);
    localparam int         PAD_W      = COIN_W - 7;

    function automatic logic [7:0] tower_cost(input logic [2:0] t);
        logic [7:0] c;
        case (t)
            3'd1:    c = 8'd100;
            3'd2:    c = 8'd120;
            3'd3:    c = 8'd160;
            3'd4:    c = 8'd220;
            default: c = 8'd0;
        endcase
        return c;
    endfunction

    function automatic logic [COIN_W:0] widen8(input logic [7:0] v);
        return {{PAD_W{1'b0}}, v};
    endfunction

    state_t                state_q, state_d;
    logic                  sell_q, sell_d;
    logic [2:0]            slot_q, slot_d;
    logic [2:0]            type_q, type_d;
    logic [COIN_W-1:0]     coins_q, coins_d;
    logic [NUM_SLOTS-1:0]  occ_q, occ_d;
    logic [NUM_SLOTS-1:0]  en_q, en_d;
    logic [NUM_SLOTS-1:0]  sellp_q, sellp_d;
    logic [2:0]            ttype_q, ttype_d;
    logic                  rv_q, rv_d;
    logic [1:0]            rc_q, rc_d;
    logic                  ready_q, ready_d;

    logic [NUM_SLOTS-1:0]  onehot_s;
    logic                  occ_hit_s;
    logic [7:0]            cost_s;
    logic [7:0]            refund_s;
    logic [1:0]            check_code_s;
    logic [COIN_W:0]       add_s, debit_s, credit_s, sum_s;

`ifdef TOWER_SELL_REFUND_EN
    logic [2:0] slot_type_q [NUM_SLOTS];
    logic [2:0] slot_type_d [NUM_SLOTS];
    logic [2:0] held_type_s;
    logic [7:0] held_cost_s;

    // Per-slot type memory: selects the held type for the refund and updates it on commit
    always_comb begin
        held_type_s = 3'd0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            held_type_s = held_type_s | (slot_type_q[i] & {3{onehot_s[i]}});
            if ((state_q == S_COMMIT) && onehot_s[i]) begin
                slot_type_d[i] = sell_q ? 3'd0 : type_q;
            end else begin
                slot_type_d[i] = slot_type_q[i];
            end
        end
        held_cost_s = tower_cost(held_type_s);
        refund_s    = {1'b0, held_cost_s[7:1]};
    end

    // Stored tower type register bank
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_type_q[i] <= 3'd0;
            end
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_type_q[i] <= slot_type_d[i];
            end
        end
    end
`else
    assign refund_s = 8'd0;
`endif

    // Priority-ordered result code for the latched command
    always_comb begin
        onehot_s  = {{(NUM_SLOTS-1){1'b0}}, 1'b1} << slot_q;
        occ_hit_s = |(occ_q & onehot_s);
        cost_s    = tower_cost(type_q);
        if (({1'b0, slot_q} >= SLOT_LIMIT) || (!sell_q && (cost_s == 8'd0))) begin
            check_code_s = RC_BAD;
        end else if (sell_q != occ_hit_s) begin
            check_code_s = RC_SLOT;
        end else if (!sell_q && ({1'b0, coins_q} < widen8(cost_s))) begin
            check_code_s = RC_COINS;
        end else begin
            check_code_s = RC_OK;
        end
    end

    // Next-state, balance arithmetic and registered-output staging
    always_comb begin
        state_d  = state_q;
        sell_d   = sell_q;
        slot_d   = slot_q;
        type_d   = type_q;
        occ_d    = occ_q;
        en_d     = {NUM_SLOTS{1'b0}};
        sellp_d  = {NUM_SLOTS{1'b0}};
        ttype_d  = 3'd0;
        rv_d     = 1'b0;
        rc_d     = RC_OK;
        debit_s  = {(COIN_W+1){1'b0}};
        credit_s = {(COIN_W+1){1'b0}};
        add_s    = coin_add_valid ? widen8(coin_add) : {(COIN_W+1){1'b0}};

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    sell_d  = cmd_sell;
                    slot_d  = cmd_slot;
                    type_d  = cmd_type;
                    state_d = S_CHECK;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CHECK: begin
                if (check_code_s == RC_OK) begin
                    state_d = S_COMMIT;
                    if (sell_q) begin
                        sellp_d = onehot_s;
                    end else begin
                        en_d    = onehot_s;
                        ttype_d = type_q;
                    end
                end else begin
                    state_d = S_RESP;
                    rv_d    = 1'b1;
                    rc_d    = check_code_s;
                end
            end
            S_COMMIT: begin
                state_d = S_RESP;
                rv_d    = 1'b1;
                rc_d    = RC_OK;
                if (sell_q) begin
                    occ_d    = occ_q & ~onehot_s;
                    credit_s = widen8(refund_s);
                end else begin
                    occ_d   = occ_q | onehot_s;
                    debit_s = widen8(cost_s);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Cost was proven affordable in CHECK and coins only grow since, so no underflow
        sum_s   = {1'b0, coins_q} + add_s + credit_s - debit_s;
        coins_d = sum_s[COIN_W] ? {COIN_W{1'b1}} : sum_s[COIN_W-1:0];
        ready_d = (state_d == S_IDLE);
    end

    // State and output registers; Reset overrides commands and rewards
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            sell_q  <= 1'b0;
            slot_q  <= 3'd0;
            type_q  <= 3'd0;
            coins_q <= COIN_W'(START_COINS);
            occ_q   <= {NUM_SLOTS{1'b0}};
            en_q    <= {NUM_SLOTS{1'b0}};
            sellp_q <= {NUM_SLOTS{1'b0}};
            ttype_q <= 3'd0;
            rv_q    <= 1'b0;
            rc_q    <= RC_OK;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            sell_q  <= sell_d;
            slot_q  <= slot_d;
            type_q  <= type_d;
            coins_q <= coins_d;
            occ_q   <= occ_d;
            en_q    <= en_d;
            sellp_q <= sellp_d;
            ttype_q <= ttype_d;
            rv_q    <= rv_d;
            rc_q    <= rc_d;
            ready_q <= ready_d;
        end
    end

    assign cmd_ready    = ready_q;
    assign tower_enable = en_q;
    assign tower_sell   = sellp_q;
    assign tower_type   = ttype_q;
    assign coins        = coins_q;
    assign occupied     = occ_q;
    assign resp_valid   = rv_q;
    assign resp_code    = rc_q;

endmodule

// File: tb/tb_tower_build_ctrl.sv
// Bench for tower_build_ctrl: transaction-level model checked every cycle, directed pins plus random traffic.
module tb_tower_build_ctrl;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_sell = 1'b0;
    logic [2:0] cmd_slot = 3'd0;
    logic [2:0] cmd_type = 3'd0;
    logic       coin_add_valid = 1'b0;
    logic [7:0] coin_add = 8'd0;
    logic [7:0] tower_enable, tower_sell, occupied;
    logic [2:0] tower_type;
    logic [11:0] coins;
    logic       resp_valid;
    logic [1:0] resp_code;

`ifdef TOWER_SELL_REFUND_EN
    localparam int REFUND_EN = 1;
`else
    localparam int REFUND_EN = 0;
`endif

    tower_build_ctrl dut (
        .Clk(Clk), .Reset(Reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_sell(cmd_sell), .cmd_slot(cmd_slot), .cmd_type(cmd_type),
        .coin_add_valid(coin_add_valid), .coin_add(coin_add),
        .tower_enable(tower_enable), .tower_sell(tower_sell), .tower_type(tower_type),
        .coins(coins), .occupied(occupied), .resp_valid(resp_valid), .resp_code(resp_code)
    );

    always #5 Clk = ~Clk;

    int n_vec = 0;
    int n_err = 0;
    int cost_tab [8];

    // model state: balance, slot contents, one in-flight command and its age in edges
    int  m_coins;
    bit  m_occ [8];
    int  m_type [8];
    bit  have_cmd;
    int  age;
    bit  c_sell;
    int  c_slot, c_type, c_code;

    logic       exp_ready, exp_rv;
    logic [7:0] exp_en, exp_sell, exp_occ;
    logic [2:0] exp_type;
    logic [1:0] exp_rc;
    int         exp_coins;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Advance the model across one rising edge using the inputs presently driven.
    task automatic model_edge();
        int delta;
        exp_en = 8'h00; exp_sell = 8'h00; exp_type = 3'd0; exp_rv = 1'b0; exp_rc = 2'b00;
        if (Reset) begin
            m_coins = 200;
            for (int i = 0; i < 8; i++) begin m_occ[i] = 1'b0; m_type[i] = 0; end
            have_cmd = 1'b0;
        end else begin
            delta = coin_add_valid ? int'(coin_add) : 0;
            if (have_cmd) begin
                age++;
                if (age == 1) begin
                    if (c_slot >= 8 || (!c_sell && cost_tab[c_type] == 0)) c_code = 3;
                    else if (c_sell ? !m_occ[c_slot] : m_occ[c_slot]) c_code = 2;
                    else if (!c_sell && m_coins < cost_tab[c_type]) c_code = 1;
                    else c_code = 0;
                    if (c_code == 0) begin
                        if (c_sell) exp_sell = 8'(1 << c_slot);
                        else begin exp_en = 8'(1 << c_slot); exp_type = 3'(c_type); end
                    end else begin
                        exp_rv = 1'b1; exp_rc = 2'(c_code);
                    end
                end else if (age == 2 && c_code == 0) begin
                    if (c_sell) begin
                        delta += REFUND_EN * (cost_tab[m_type[c_slot]] / 2);
                        m_occ[c_slot] = 1'b0; m_type[c_slot] = 0;
                    end else begin
                        delta -= cost_tab[c_type];
                        m_occ[c_slot] = 1'b1; m_type[c_slot] = c_type;
                    end
                    exp_rv = 1'b1;
                end
                if ((c_code == 0 && age == 3) || (c_code != 0 && age == 2)) have_cmd = 1'b0;
            end else if (cmd_valid) begin
                have_cmd = 1'b1; age = 0;
                c_sell = cmd_sell; c_slot = int'(cmd_slot); c_type = int'(cmd_type);
            end
            m_coins += delta;
            if (m_coins > 4095) m_coins = 4095;
        end
        exp_ready = !have_cmd;
        exp_coins = m_coins;
        for (int i = 0; i < 8; i++) exp_occ[i] = m_occ[i];
    endtask

    task automatic tick();
        model_edge();
        @(posedge Clk);
        @(negedge Clk);
        chk("cmd_ready", 32'(cmd_ready), 32'(exp_ready));
        chk("tower_enable", 32'(tower_enable), 32'(exp_en));
        chk("tower_sell", 32'(tower_sell), 32'(exp_sell));
        chk("tower_type", 32'(tower_type), 32'(exp_type));
        chk("coins", 32'(coins), 32'(exp_coins));
        chk("occupied", 32'(occupied), 32'(exp_occ));
        chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
        chk("resp_code", 32'(resp_code), 32'(exp_rc));
    endtask

    task automatic do_reset();
        Reset = 1'b1; tick(); Reset = 1'b0;
    endtask

    task automatic send(input bit s, input int sl, input int ty);
        cmd_valid = 1'b1; cmd_sell = s; cmd_slot = 3'(sl); cmd_type = 3'(ty);
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        cost_tab = '{0, 100, 120, 160, 220, 0, 0, 0};
        do_reset();
        tick();
        chk("rst_coins", 32'(coins), 32'd200);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_occ", 32'(occupied), 32'd0);

        // place type 1 on slot 3
        send(1'b0, 3, 1);
        tick();
        chk("place_en", 32'(tower_enable), 32'h08);
        chk("place_type", 32'(tower_type), 32'd1);
        tick();
        chk("place_rv", 32'(resp_valid), 32'd1);
        chk("place_rc", 32'(resp_code), 32'd0);
        chk("place_coins", 32'(coins), 32'd100);
        chk("place_occ", 32'(occupied), 32'h08);
        tick();

        // sell slot 3
        send(1'b1, 3, 0);
        tick();
        chk("sell_pulse", 32'(tower_sell), 32'h08);
        chk("sell_no_en", 32'(tower_enable), 32'h00);
        tick();
        chk("sell_occ", 32'(occupied), 32'h00);
        chk("sell_coins", 32'(coins), 32'(100 + 50 * REFUND_EN));
        tick();

        // busy / empty / bad-type rejects
        send(1'b0, 3, 1); tick(); tick(); tick();
        send(1'b0, 3, 1); tick();
        chk("busy_rc", 32'(resp_code), 32'd2);
        chk("busy_rv", 32'(resp_valid), 32'd1);
        tick();
        send(1'b1, 5, 0); tick();
        chk("empty_rc", 32'(resp_code), 32'd2);
        tick();
        send(1'b0, 2, 6); tick();
        chk("badtype_rc", 32'(resp_code), 32'd3);
        tick();

        // insufficient coins
        do_reset();
        send(1'b0, 0, 4); tick();
        chk("poor_rv", 32'(resp_valid), 32'd1);
        chk("poor_rc", 32'(resp_code), 32'd1);
        chk("poor_en", 32'(tower_enable), 32'd0);
        chk("poor_coins", 32'(coins), 32'd200);
        tick();

        // reward coinciding with commit, then saturation
        do_reset();
        send(1'b0, 1, 2); tick();
        coin_add_valid = 1'b1; coin_add = 8'd30;
        tick();
        chk("add_commit_coins", 32'(coins), 32'd110);
        coin_add = 8'd255;
        for (int i = 0; i < 20; i++) tick();
        chk("sat_coins", 32'(coins), 32'd4095);
        coin_add_valid = 1'b0;
        tick();

        // Reset during CHECK abandons the command
        do_reset();
        send(1'b0, 1, 1);
        Reset = 1'b1; tick(); Reset = 1'b0;
        chk("abort_en", 32'(tower_enable), 32'd0);
        chk("abort_rv", 32'(resp_valid), 32'd0);
        chk("abort_coins", 32'(coins), 32'd200);
        chk("abort_occ", 32'(occupied), 32'd0);
        chk("abort_ready", 32'(cmd_ready), 32'd1);
        tick();
        chk("abort_rv2", 32'(resp_valid), 32'd0);

        // random traffic
        for (int n = 0; n < 4000; n++) begin
            Reset          = ($urandom_range(0, 199) == 0);
            cmd_valid      = ($urandom_range(0, 1) == 1);
            cmd_sell       = ($urandom_range(0, 2) == 0);
            cmd_slot       = 3'($urandom_range(0, 7));
            cmd_type       = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(1, 4));
            coin_add_valid = ($urandom_range(0, 5) == 0);
            coin_add       = 8'($urandom_range(0, 60));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
